// File: rtl/demux1_to_2.sv
// Registered 1-to-2 demux: steers each accepted word into per-destination FIFO A (sel=1) or B (sel=0).
// One-cycle latency to the output port; a full destination stalls only the words aimed at it.

module demux1_to_2_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    // A pop request against an empty FIFO is dropped so the count cannot underflow.
    assign pop     = pop_i & valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_i && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

module demux1_to_2 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count
);

    logic a_full, b_full;
    logic push_a, push_b;

    // Ready looks only at registered occupancy, never at the consumer readies.
    assign in_ready = in_sel ? !a_full : !b_full;
    assign push_a   = in_valid & in_ready &  in_sel;
    assign push_b   = in_valid & in_ready & !in_sel;

    demux1_to_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_a),
        .push_data_i (in_data),
        .pop_i       (a_ready),
        .data_o      (a_data),
        .valid_o     (a_valid),
        .count_o     (a_count),
        .full_o      (a_full)
    );

    demux1_to_2_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push_b),
        .push_data_i (in_data),
        .pop_i       (b_ready),
        .data_o      (b_data),
        .valid_o     (b_valid),
        .count_o     (b_count),
        .full_o      (b_full)
    );

endmodule
